// File: rtl/obi_axi_sl_bridge_if.sv
// ============================================================================
// Module      : obi_axi_sl_bridge_if
// Description : OBI slave port plus single-beat AXI4 master channels for the
//               OBI-to-AXI serial-link bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface obi_axi_sl_bridge_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4
);
    // OBI
    logic                   obi_req_i;
    logic                   obi_gnt_o;
    logic [AddrWidth-1:0]   obi_addr_i;
    logic                   obi_we_i;
    logic [DataWidth/8-1:0] obi_be_i;
    logic [DataWidth-1:0]   obi_wdata_i;
    logic                   obi_rvalid_o;
    logic [DataWidth-1:0]   obi_rdata_o;
    logic                   obi_err_o;
    // AXI write address
    logic                   aw_valid_o;
    logic                   aw_ready_i;
    logic [AddrWidth-1:0]   aw_addr_o;
    logic [IdWidth-1:0]     aw_id_o;
    logic [7:0]             aw_len_o;
    logic [2:0]             aw_size_o;
    logic [1:0]             aw_burst_o;
    // AXI write data
    logic                   w_valid_o;
    logic                   w_ready_i;
    logic [DataWidth-1:0]   w_data_o;
    logic [DataWidth/8-1:0] w_strb_o;
    logic                   w_last_o;
    // AXI write response
    logic                   b_valid_i;
    logic                   b_ready_o;
    logic [1:0]             b_resp_i;
    logic [IdWidth-1:0]     b_id_i;
    // AXI read address
    logic                   ar_valid_o;
    logic                   ar_ready_i;
    logic [AddrWidth-1:0]   ar_addr_o;
    logic [IdWidth-1:0]     ar_id_o;
    logic [7:0]             ar_len_o;
    logic [2:0]             ar_size_o;
    logic [1:0]             ar_burst_o;
    // AXI read data
    logic                   r_valid_i;
    logic                   r_ready_o;
    logic [DataWidth-1:0]   r_data_i;
    logic [1:0]             r_resp_i;
    logic                   r_last_i;
    logic [IdWidth-1:0]     r_id_i;

    // Bridge side
    modport slave (
        input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        output aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o,
        input  aw_ready_i,
        output w_valid_o, w_data_o, w_strb_o, w_last_o,
        input  w_ready_i,
        input  b_valid_i, b_resp_i, b_id_i,
        output b_ready_o,
        output ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o,
        input  ar_ready_i,
        input  r_valid_i, r_data_i, r_resp_i, r_last_i, r_id_i,
        output r_ready_o
    );

    // OBI master / AXI slave side
    modport master (
        output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        input  aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o,
        output aw_ready_i,
        input  w_valid_o, w_data_o, w_strb_o, w_last_o,
        output w_ready_i,
        output b_valid_i, b_resp_i, b_id_i,
        input  b_ready_o,
        input  ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o,
        output ar_ready_i,
        output r_valid_i, r_data_i, r_resp_i, r_last_i, r_id_i,
        input  r_ready_o
    );
endinterface

`default_nettype wire

// File: rtl/obi_axi_sl_bridge.sv
// ============================================================================
// Module      : obi_axi_sl_bridge
// Description : OBI slave to AXI4 master bridge, one single-beat transaction
//               in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_axi_sl_bridge #(
    parameter int            AddrWidth = 32,
    parameter int            DataWidth = 32,
    parameter int            IdWidth   = 4,
    parameter logic [IdWidth-1:0] AxiId = '0
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    obi_axi_sl_bridge_if.slave      bus,
    output logic                    busy_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_AD   = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam int                   c_OFF       = $clog2(DataWidth/8);
    localparam logic [2:0]           c_SIZE      = 3'(c_OFF);
    localparam logic [AddrWidth-1:0] c_ADDR_MASK = ~(AddrWidth'((1 << c_OFF) - 1));

    logic [2:0]             r_state;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth/8-1:0] r_be;
    logic [DataWidth-1:0]   r_wdata;
    logic [DataWidth-1:0]   r_rdata;
    logic                   r_err;
    logic                   r_aw_done;
    logic                   r_w_done;

    logic w_aw_fin;
    logic w_w_fin;
    logic w_b_err;
    logic w_r_err;

    // Handshake-complete flags include the handshake happening this cycle
    assign w_aw_fin = r_aw_done | (bus.aw_valid_o & bus.aw_ready_i);
    assign w_w_fin  = r_w_done  | (bus.w_valid_o  & bus.w_ready_i);
    assign w_b_err  = (bus.b_resp_i >= 2'b10) | (bus.b_id_i != AxiId);
    assign w_r_err  = (bus.r_resp_i >= 2'b10) | ~bus.r_last_i | (bus.r_id_i != AxiId);

    assign bus.obi_gnt_o    = (r_state == S_IDLE) & bus.obi_req_i;
    assign bus.obi_rvalid_o = (r_state == S_RESP);
    assign bus.obi_rdata_o  = r_rdata;
    assign bus.obi_err_o    = (r_state == S_RESP) & r_err;

    assign bus.aw_valid_o = (r_state == S_WR_AD) & ~r_aw_done;
    assign bus.aw_addr_o  = r_addr & c_ADDR_MASK;
    assign bus.aw_id_o    = AxiId;
    assign bus.aw_len_o   = 8'd0;
    assign bus.aw_size_o  = c_SIZE;
    assign bus.aw_burst_o = 2'b01;

    assign bus.w_valid_o  = (r_state == S_WR_AD) & ~r_w_done;
    assign bus.w_data_o   = r_wdata;
    assign bus.w_strb_o   = r_be;
    assign bus.w_last_o   = 1'b1;

    assign bus.b_ready_o  = (r_state == S_WR_RESP);

    assign bus.ar_valid_o = (r_state == S_RD_ADDR);
    assign bus.ar_addr_o  = r_addr & c_ADDR_MASK;
    assign bus.ar_id_o    = AxiId;
    assign bus.ar_len_o   = 8'd0;
    assign bus.ar_size_o  = c_SIZE;
    assign bus.ar_burst_o = 2'b01;

    assign bus.r_ready_o  = (r_state == S_RD_DATA);

    assign busy_o = (r_state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.obi_req_i) begin
                        r_addr  <= bus.obi_addr_i;
                        r_be    <= bus.obi_be_i;
                        r_wdata <= bus.obi_wdata_i;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_state <= bus.obi_we_i ? S_WR_AD : S_RD_ADDR;
                    end
                end
                S_WR_AD: begin
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_WR_RESP;
                    end else begin
                        r_aw_done <= w_aw_fin;
                        r_w_done  <= w_w_fin;
                    end
                end
                S_WR_RESP: begin
                    if (bus.b_valid_i) begin
                        r_err   <= w_b_err;
                        r_state <= S_RESP;
                    end
                end
                S_RD_ADDR: begin
                    if (bus.ar_ready_i) r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (bus.r_valid_i) begin
                        r_err   <= w_r_err;
                        r_rdata <= w_r_err ? '0 : bus.r_data_i;
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    a_aw_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.aw_valid_o && !bus.aw_ready_i |=> bus.aw_valid_o && $stable(bus.aw_addr_o));
    a_w_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.w_valid_o && !bus.w_ready_i |=> bus.w_valid_o && $stable(bus.w_data_o) && $stable(bus.w_strb_o));
    a_ar_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.ar_valid_o && !bus.ar_ready_i |=> bus.ar_valid_o && $stable(bus.ar_addr_o));
    a_one_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.obi_gnt_o |-> !busy_o && !bus.obi_rvalid_o);

endmodule

`default_nettype wire

// File: tb/tb_obi_axi_sl_bridge.sv
// ============================================================================
// Module      : tb_obi_axi_sl_bridge
// Description : Directed self-checking bench for obi_axi_sl_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_axi_sl_bridge;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    obi_axi_sl_bridge_if bus ();

    obi_axi_sl_bridge dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units later
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.obi_req_i   = 1'b0;
        bus.obi_addr_i  = '0;
        bus.obi_we_i    = 1'b0;
        bus.obi_be_i    = '0;
        bus.obi_wdata_i = '0;
        bus.aw_ready_i  = 1'b0;
        bus.w_ready_i   = 1'b0;
        bus.b_valid_i   = 1'b0;
        bus.b_resp_i    = 2'b00;
        bus.b_id_i      = '0;
        bus.ar_ready_i  = 1'b0;
        bus.r_valid_i   = 1'b0;
        bus.r_data_i    = '0;
        bus.r_resp_i    = 2'b00;
        bus.r_last_i    = 1'b0;
        bus.r_id_i      = '0;
    endtask

    // aw_cyc = number of cycles aw_valid stays high (1 = ready immediately)
    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                            input int aw_cyc, input logic [1:0] bresp, input logic [3:0] bid,
                            input logic [31:0] exp_addr, input logic exp_err);
        bus.obi_req_i   = 1'b1;
        bus.obi_we_i    = 1'b1;
        bus.obi_addr_i  = addr;
        bus.obi_be_i    = be;
        bus.obi_wdata_i = data;
        bus.w_ready_i   = 1'b1;
        #1;
        chk("wr_gnt", 64'(bus.obi_gnt_o), 64'd1);
        tick();
        bus.obi_req_i = 1'b0;
        chk("wr_aw_addr", 64'(bus.aw_addr_o), 64'(exp_addr));
        chk("wr_strb", 64'(bus.w_strb_o), 64'(be));
        chk("wr_wdata", 64'(bus.w_data_o), 64'(data));
        chk("wr_fixed", {bus.aw_len_o, 1'b0, bus.aw_size_o, 2'b0, bus.aw_burst_o, 3'b0, bus.w_last_o, bus.aw_id_o},
            {8'd0, 1'b0, 3'd2, 2'b0, 2'b01, 3'b0, 1'b1, 4'd0});
        for (int c = 1; c <= aw_cyc; c++) begin
            bus.aw_ready_i = (c == aw_cyc);
            #1;
            chk("wr_aw_valid", 64'(bus.aw_valid_o), 64'd1);
            chk("wr_w_valid", 64'(bus.w_valid_o), 64'(c == 1));
            chk("wr_b_ready_early", 64'(bus.b_ready_o), 64'd0);
            tick();
        end
        bus.aw_ready_i = 1'b0;
        chk("wr_valids_low", {bus.aw_valid_o, bus.w_valid_o}, 2'b00);
        chk("wr_b_ready", 64'(bus.b_ready_o), 64'd1);
        chk("wr_no_rvalid", 64'(bus.obi_rvalid_o), 64'd0);
        bus.b_valid_i = 1'b1;
        bus.b_resp_i  = bresp;
        bus.b_id_i    = bid;
        tick();
        bus.b_valid_i = 1'b0;
        chk("wr_rvalid", 64'(bus.obi_rvalid_o), 64'd1);
        chk("wr_err", 64'(bus.obi_err_o), 64'(exp_err));
        chk("wr_rdata", 64'(bus.obi_rdata_o), 64'd0);
        chk("wr_b_ready_resp", 64'(bus.b_ready_o), 64'd0);
        tick();
        chk("wr_rvalid_pulse", 64'(bus.obi_rvalid_o), 64'd0);
        chk("wr_idle", 64'(busy), 64'd0);
        bus.w_ready_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata, input logic [1:0] rresp,
                           input logic rlast, input logic [3:0] rid, input logic [31:0] exp_addr,
                           input logic exp_err, input logic [31:0] exp_rdata);
        bus.obi_req_i  = 1'b1;
        bus.obi_we_i   = 1'b0;
        bus.obi_addr_i = addr;
        #1;
        chk("rd_gnt", 64'(bus.obi_gnt_o), 64'd1);
        tick();
        bus.obi_req_i  = 1'b0;
        bus.ar_ready_i = 1'b1;
        chk("rd_ar_valid", 64'(bus.ar_valid_o), 64'd1);
        chk("rd_ar_addr", 64'(bus.ar_addr_o), 64'(exp_addr));
        chk("rd_fixed", {bus.ar_len_o, 1'b0, bus.ar_size_o, 2'b0, bus.ar_burst_o, bus.ar_id_o},
            {8'd0, 1'b0, 3'd2, 2'b0, 2'b01, 4'd0});
        chk("rd_r_ready_early", 64'(bus.r_ready_o), 64'd0);
        tick();
        bus.ar_ready_i = 1'b0;
        chk("rd_ar_low", 64'(bus.ar_valid_o), 64'd0);
        chk("rd_r_ready", 64'(bus.r_ready_o), 64'd1);
        bus.r_valid_i = 1'b1;
        bus.r_data_i  = rdata;
        bus.r_resp_i  = rresp;
        bus.r_last_i  = rlast;
        bus.r_id_i    = rid;
        tick();
        bus.r_valid_i = 1'b0;
        chk("rd_rvalid", 64'(bus.obi_rvalid_o), 64'd1);
        chk("rd_err", 64'(bus.obi_err_o), 64'(exp_err));
        chk("rd_rdata", 64'(bus.obi_rdata_o), 64'(exp_rdata));
        tick();
        chk("rd_rvalid_pulse", 64'(bus.obi_rvalid_o), 64'd0);
        chk("rd_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        #12;
        chk("rst_outs", {bus.obi_gnt_o, bus.obi_rvalid_o, bus.obi_err_o, busy,
                         bus.aw_valid_o, bus.w_valid_o, bus.ar_valid_o, bus.b_ready_o, bus.r_ready_o}, 9'd0);
        chk("rst_rdata", 64'(bus.obi_rdata_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Aligned write, everything ready at once
        do_write(32'h1000_0004, 4'b0011, 32'hDEAD_BEEF, 1, 2'b00, 4'd0, 32'h1000_0004, 1'b0);
        // Read with OKAY
        do_read(32'h2000_0008, 32'hCAFE_F00D, 2'b00, 1'b1, 4'd0, 32'h2000_0008, 1'b0, 32'hCAFE_F00D);
        // AW accepted only in the third cycle, W immediately
        do_write(32'h1000_0010, 4'b1111, 32'h1234_5678, 3, 2'b00, 4'd0, 32'h1000_0010, 1'b0);
        // Error responses
        do_read(32'h2000_000C, 32'h5555_AAAA, 2'b10, 1'b1, 4'd0, 32'h2000_000C, 1'b1, 32'd0);
        do_write(32'h1000_0020, 4'b0001, 32'h0000_00FF, 1, 2'b11, 4'd0, 32'h1000_0020, 1'b1);
        // Unaligned address is truncated to a word
        do_write(32'h3000_0006, 4'b1100, 32'hA5A5_0000, 1, 2'b00, 4'd0, 32'h3000_0004, 1'b0);
        // Wrong B id, missing RLAST, wrong R id all flag an error
        do_write(32'h1000_0030, 4'b1111, 32'h0, 1, 2'b00, 4'd1, 32'h1000_0030, 1'b1);
        do_read(32'h2000_0010, 32'h1111_2222, 2'b00, 1'b0, 4'd0, 32'h2000_0010, 1'b1, 32'd0);
        do_read(32'h2000_0014, 32'h3333_4444, 2'b01, 1'b1, 4'd2, 32'h2000_0014, 1'b1, 32'd0);
        // EXOKAY is not an error
        do_read(32'h2000_0018, 32'h7777_8888, 2'b01, 1'b1, 4'd0, 32'h2000_0018, 1'b0, 32'h7777_8888);

        // Spurious responses while idle are not consumed
        bus.b_valid_i = 1'b1;
        bus.r_valid_i = 1'b1;
        #1;
        chk("spur_readys", {bus.b_ready_o, bus.r_ready_o}, 2'b00);
        tick();
        chk("spur_busy", 64'(busy), 64'd0);
        chk("spur_rvalid", 64'(bus.obi_rvalid_o), 64'd0);
        bus.b_valid_i = 1'b0;
        bus.r_valid_i = 1'b0;

        // Request held high: grant only in IDLE, no second AR before the response pulse
        bus.obi_req_i  = 1'b1;
        bus.obi_we_i   = 1'b0;
        bus.obi_addr_i = 32'h4000_0000;
        bus.ar_ready_i = 1'b1;
        bus.r_valid_i  = 1'b1;
        bus.r_last_i   = 1'b1;
        bus.r_resp_i   = 2'b00;
        bus.r_id_i     = 4'd0;
        bus.r_data_i   = 32'h0BAD_F00D;
        #1;
        chk("hold_c0", {bus.obi_gnt_o, bus.ar_valid_o, bus.obi_rvalid_o}, 3'b100);
        tick();
        chk("hold_c1", {bus.obi_gnt_o, bus.ar_valid_o, bus.obi_rvalid_o}, 3'b010);
        tick();
        chk("hold_c2", {bus.obi_gnt_o, bus.ar_valid_o, bus.obi_rvalid_o}, 3'b000);
        tick();
        chk("hold_c3", {bus.obi_gnt_o, bus.ar_valid_o, bus.obi_rvalid_o}, 3'b001);
        chk("hold_rdata", 64'(bus.obi_rdata_o), 64'h0BAD_F00D);
        tick();
        chk("hold_c4", {bus.obi_gnt_o, bus.ar_valid_o, bus.obi_rvalid_o}, 3'b100);
        tick();
        bus.obi_req_i = 1'b0;
        chk("hold_c5", {bus.obi_gnt_o, bus.ar_valid_o, bus.obi_rvalid_o}, 3'b010);
        tick();
        tick();
        chk("hold_c7", 64'(bus.obi_rvalid_o), 64'd1);
        tick();
        chk("hold_done", 64'(busy), 64'd0);
        idle_inputs();

        // Reset while waiting for B
        bus.obi_req_i   = 1'b1;
        bus.obi_we_i    = 1'b1;
        bus.obi_addr_i  = 32'h5000_0000;
        bus.obi_be_i    = 4'hF;
        bus.obi_wdata_i = 32'h0F0F_0F0F;
        bus.aw_ready_i  = 1'b1;
        bus.w_ready_i   = 1'b1;
        tick();
        bus.obi_req_i = 1'b0;
        tick();
        chk("rst_mid_b_ready", 64'(bus.b_ready_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {bus.aw_valid_o, bus.w_valid_o, bus.ar_valid_o, bus.b_ready_o,
                             bus.r_ready_o, bus.obi_rvalid_o, busy}, 7'd0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        do_read(32'h6000_0004, 32'hFEED_FACE, 2'b00, 1'b1, 4'd0, 32'h6000_0004, 1'b0, 32'hFEED_FACE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
